// File: rtl/bash_io_pkg.sv
// Shared definitions for the bash terminal line editor: ASCII codes,
// editor states and the default line capacity.
package bash_io_pkg;

  localparam logic [7:0] NUL      = 8'h00;
  localparam logic [7:0] BS       = 8'h08;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  localparam int unsigned MAX_LEN_DEF = 32;

  typedef enum logic [2:0] {
    EDIT,
    SEND,
    WAIT,
    PRINT,
    DRAIN
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/term_echo_slot.sv
// One-entry register feeding the video-memory character writer.
// Loads only when empty; empties on a valid/ready handshake.
module term_echo_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load && !valid) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bash_line_io.sv
// Terminal line editor: collects keys into a line, echoes them, offers the
// finished line to the bash app, then prints and acknowledges its reply.
module bash_line_io
  import bash_io_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned LEN_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kb_valid,
  input  logic [7:0]       kb_ascii,
  output logic             term_valid,
  output logic [7:0]       term_ascii,
  input  logic             term_ready,
  output logic             out_newASCII_ready,
  output logic [LEN_W-1:0] out_lineLen,
  output logic [7:0]       lineOut,
  input  logic             lineOut_nextASCII,
  input  logic             in_newASCII_ready,
  input  logic [7:0]       lineIn,
  output logic             lineIn_nextASCII,
  input  logic             in_solved,
  output logic             out_solved,
  output logic             kb_overflow
);

  localparam int unsigned      IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] rd;
  logic [7:0]       line_buf [MAX_LEN];
  logic             gap;
  logic             lf_pend;
  logic             echo_load;
  logic [7:0]       echo_char;
  logic             buf_we;

  term_echo_slot #(.W(8)) u_echo (
    .clk       (clk),
    .rst       (rst),
    .load      (echo_load),
    .load_data (echo_char),
    .ready     (term_ready),
    .valid     (term_valid),
    .data      (term_ascii)
  );

  // Everything that may write the echo slot is decided here, so the FSM
  // below only needs echo_load to know whether a reply char was taken.
  always_comb begin
    echo_load = 1'b0;
    echo_char = NUL;
    buf_we    = 1'b0;
    case (state)
      EDIT: begin
        if (kb_valid && !term_valid) begin
          if (is_printable(kb_ascii) && (len < MAX_L)) begin
            echo_load = 1'b1;
            echo_char = kb_ascii;
            buf_we    = 1'b1;
          end else if ((kb_ascii == BS) && (len != '0)) begin
            echo_load = 1'b1;
            echo_char = BS;
          end else if ((kb_ascii == CR) || (kb_ascii == LF)) begin
            echo_load = 1'b1;
            echo_char = LF;
          end
        end
      end
      PRINT: begin
        if (!in_solved && (lineIn != NUL) && !term_valid && !gap) begin
          echo_load = 1'b1;
          echo_char = lineIn;
        end
      end
      DRAIN: begin
        if (lf_pend && !term_valid) begin
          echo_load = 1'b1;
          echo_char = LF;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (buf_we && !rst) line_buf[len[IDX_W-1:0]] <= kb_ascii;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= EDIT;
      len                <= '0;
      rd                 <= '0;
      out_newASCII_ready <= 1'b0;
      lineIn_nextASCII   <= 1'b0;
      out_solved         <= 1'b0;
      kb_overflow        <= 1'b0;
      gap                <= 1'b0;
      lf_pend            <= 1'b0;
    end else begin
      lineIn_nextASCII <= 1'b0;
      out_solved       <= 1'b0;
      gap              <= 1'b0;
      case (state)
        EDIT: begin
          if (kb_valid) begin
            if (term_valid) begin
              kb_overflow <= 1'b1;
            end else if (is_printable(kb_ascii) && (len < MAX_L)) begin
              len <= len + LEN_W'(1);
            end else if ((kb_ascii == BS) && (len != '0)) begin
              len <= len - LEN_W'(1);
            end else if ((kb_ascii == CR) || (kb_ascii == LF)) begin
              rd    <= '0;
              state <= SEND;
            end
          end
          // An unsolicited reply wins the state; the line buffer is kept.
          if (in_newASCII_ready) state <= PRINT;
        end
        SEND: begin
          if (!out_newASCII_ready) begin
            out_newASCII_ready <= 1'b1;
          end else if (lineOut_nextASCII) begin
            if (rd != len) begin
              rd <= rd + LEN_W'(1);
            end else begin
              out_newASCII_ready <= 1'b0;
              len                <= '0;
              state              <= WAIT;
            end
          end
        end
        WAIT: begin
          if (in_newASCII_ready) state <= PRINT;
        end
        PRINT: begin
          if (in_solved) begin
            out_solved <= 1'b1;
            lf_pend    <= 1'b1;
            state      <= DRAIN;
          end else if (echo_load) begin
            lineIn_nextASCII <= 1'b1;
            gap              <= 1'b1;
          end
        end
        DRAIN: begin
          if (echo_load) lf_pend <= 1'b0;
          if (!in_solved && !term_valid && !lf_pend) state <= EDIT;
        end
        default: state <= EDIT;
      endcase
    end
  end

  assign out_lineLen = out_newASCII_ready ? len : '0;
  assign lineOut     = (out_newASCII_ready && (rd != len)) ?
                       line_buf[rd[IDX_W-1:0]] : NUL;

endmodule

// File: tb/tb_bash_line_io.sv
// Directed bench for bash_line_io: table of typed lines answered by an
// echo-app model, plus hand-written latency, overflow and reset sequences.
module tb_bash_line_io;

  logic       clk;
  logic       rst;
  logic       kb_valid;
  logic [7:0] kb_ascii;
  logic       term_valid;
  logic [7:0] term_ascii;
  logic       term_ready;
  logic       out_newASCII_ready;
  logic [5:0] out_lineLen;
  logic [7:0] lineOut;
  logic       lineOut_nextASCII;
  logic       in_newASCII_ready;
  logic [7:0] lineIn;
  logic       lineIn_nextASCII;
  logic       in_solved;
  logic       out_solved;
  logic       kb_overflow;

  bash_line_io #(.MAX_LEN(32), .LEN_W(6)) dut (
    .clk                (clk),
    .rst                (rst),
    .kb_valid           (kb_valid),
    .kb_ascii           (kb_ascii),
    .term_valid         (term_valid),
    .term_ascii         (term_ascii),
    .term_ready         (term_ready),
    .out_newASCII_ready (out_newASCII_ready),
    .out_lineLen        (out_lineLen),
    .lineOut            (lineOut),
    .lineOut_nextASCII  (lineOut_nextASCII),
    .in_newASCII_ready  (in_newASCII_ready),
    .lineIn             (lineIn),
    .lineIn_nextASCII   (lineIn_nextASCII),
    .in_solved          (in_solved),
    .out_solved         (out_solved),
    .kb_overflow        (kb_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  int  consec = 0;
  byte term_q[$];
  logic prev_nx = 1'b0;
  logic prev_sol = 1'b0;

  always @(negedge clk) begin
    if (term_valid && term_ready && !rst) term_q.push_back(term_ascii);
    if (lineIn_nextASCII && prev_nx) consec++;
    if (out_solved && prev_sol) consec++;
    prev_nx  = lineIn_nextASCII;
    prev_sol = out_solved;
  end

  typedef struct {
    string keys;
    string line;
    string term;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic type_keys(input string k);
    for (int i = 0; i < k.len(); i++) begin
      kb_ascii = k[i];
      kb_valid = 1'b1;
      step(1);
      kb_valid = 1'b0;
      step(2);
    end
  endtask

  task automatic consume_line(input string e);
    for (int w = 0; w < 20 && !out_newASCII_ready; w++) step(1);
    check("send_ready", int'(out_newASCII_ready), 1);
    for (int i = 0; i <= e.len(); i++) begin
      check("lineLen", int'(out_lineLen), e.len());
      check("lineOut", int'(lineOut), (i < e.len()) ? int'(e[i]) : 0);
      lineOut_nextASCII = 1'b1;
      step(1);
      lineOut_nextASCII = 1'b0;
      step(1);
    end
    check("send_done", int'(out_newASCII_ready), 0);
  endtask

  task automatic app_reply(input string r);
    int   idx;
    int   solved;
    int   nx;
    logic adv;
    logic sol;
    idx = 0;
    solved = 0;
    nx = 0;
    in_newASCII_ready = 1'b1;
    in_solved = (r.len() == 0);
    lineIn = (r.len() > 0) ? r[0] : 8'h00;
    for (int c = 0; c < 400 && solved == 0; c++) begin
      @(negedge clk);
      adv = lineIn_nextASCII;
      sol = out_solved;
      @(posedge clk);
      #1;
      if (adv) begin
        idx++;
        nx++;
      end
      if (sol) begin
        solved++;
        in_solved = 1'b0;
        in_newASCII_ready = 1'b0;
      end else if (idx >= r.len()) begin
        in_solved = 1'b1;
      end
      lineIn = (idx < r.len()) ? r[idx] : 8'h00;
    end
    in_solved = 1'b0;
    in_newASCII_ready = 1'b0;
    lineIn = 8'h00;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_solved) solved++;
      if (lineIn_nextASCII) nx++;
    end
    @(posedge clk);
    #1;
    check("solved_pulses", solved, 1);
    check("next_pulses", nx, r.len());
  endtask

  task automatic check_term(input string e);
    check("term_count", term_q.size(), e.len());
    for (int i = 0; i < e.len() && i < term_q.size(); i++)
      check("term_char", int'(term_q[i]), int'(e[i]));
    term_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t  tv[6];
    string l33;
    string l32;
    l33 = "0123456789ABCDEFGHIJKLMNOPQRSTUVW";
    l32 = l33.substr(0, 31);
    tv[0] = '{keys: "abc\015",               line: "abc",  term: "abc\012abc\012"};
    tv[1] = '{keys: "ab\010\010\010x\015",   line: "x",    term: "ab\010\010x\012x\012"};
    tv[2] = '{keys: "\015",                  line: "",     term: "\012\012"};
    tv[3] = '{keys: {l33, "\015"},           line: l32,    term: {l32, "\012", l32, "\012"}};
    tv[4] = '{keys: "Hi!\001~\015",          line: "Hi!~", term: "Hi!~\012Hi!~\012"};
    tv[5] = '{keys: "z\010\010\012",         line: "",     term: "z\010\012\012"};

    rst = 1'b1;
    kb_valid = 1'b0;
    kb_ascii = 8'h00;
    term_ready = 1'b1;
    lineOut_nextASCII = 1'b0;
    in_newASCII_ready = 1'b0;
    lineIn = 8'h00;
    in_solved = 1'b0;
    step(3);
    rst = 1'b0;
    check("rst_term_valid", int'(term_valid), 0);
    check("rst_send_ready", int'(out_newASCII_ready), 0);
    check("rst_lineLen", int'(out_lineLen), 0);
    check("rst_lineOut", int'(lineOut), 0);
    check("rst_next", int'(lineIn_nextASCII), 0);
    check("rst_solved", int'(out_solved), 0);
    check("rst_overflow", int'(kb_overflow), 0);

    for (int v = 0; v < 6; v++) begin
      term_q.delete();
      type_keys(tv[v].keys);
      consume_line(tv[v].line);
      app_reply(tv[v].line);
      check_term(tv[v].term);
      check("no_overflow", int'(kb_overflow), 0);
    end

    // Latency: key -> echo one cycle, Enter -> line offered two cycles.
    term_q.delete();
    kb_ascii = "k";
    kb_valid = 1'b1;
    @(negedge clk);
    check("lat_key_pre", int'(term_valid), 0);
    @(posedge clk);
    #1;
    kb_valid = 1'b0;
    check("lat_key_valid", int'(term_valid), 1);
    check("lat_key_char", int'(term_ascii), 8'h6B);
    step(2);
    kb_ascii = 8'h0D;
    kb_valid = 1'b1;
    step(1);
    kb_valid = 1'b0;
    check("lat_enter_echo", int'(term_ascii), 8'h0A);
    check("lat_enter_early", int'(out_newASCII_ready), 0);
    step(1);
    check("lat_enter_ready", int'(out_newASCII_ready), 1);
    consume_line("k");
    app_reply("k");
    check_term("k\012k\012");

    // Unsolicited reply while editing keeps the partial line.
    type_keys("ab");
    app_reply("Z");
    type_keys("\015");
    consume_line("ab");
    app_reply("ab");
    check_term("abZ\012\012ab\012");

    // Stalled video memory: first key held, second dropped, flag sticky.
    term_ready = 1'b0;
    kb_ascii = "p";
    kb_valid = 1'b1;
    step(1);
    kb_ascii = "q";
    step(1);
    kb_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("stall_valid", int'(term_valid), 1);
      check("stall_char", int'(term_ascii), 8'h70);
      step(1);
    end
    check("overflow_set", int'(kb_overflow), 1);
    term_ready = 1'b1;
    step(2);
    type_keys("\015");
    consume_line("p");
    app_reply("p");
    check_term("p\012p\012");
    check("overflow_sticky", int'(kb_overflow), 1);

    // Reset in the middle of offering a line.
    type_keys("mnop\015");
    for (int w = 0; w < 20 && !out_newASCII_ready; w++) step(1);
    for (int p = 0; p < 2; p++) begin
      lineOut_nextASCII = 1'b1;
      step(1);
      lineOut_nextASCII = 1'b0;
      step(1);
    end
    check("midsend_lineOut", int'(lineOut), 8'h6F);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midrst_ready", int'(out_newASCII_ready), 0);
    check("midrst_term_valid", int'(term_valid), 0);
    check("midrst_solved", int'(out_solved), 0);
    check("midrst_overflow", int'(kb_overflow), 0);
    check("midrst_lineOut", int'(lineOut), 0);
    term_q.delete();
    type_keys("q\015");
    consume_line("q");
    app_reply("q");
    check_term("q\012q\012");

    check("pulse_spacing", consec, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
